// File: rtl/tile_renderer.sv
// tile_renderer: fetches name/pattern/color bytes for each 8-pixel tile
// column from video RAM, then serializes the pattern bits into palette
// indices. The fetch phase comes straight from xPos[2:0], so any horizontal
// shift of xPos moves the fetch schedule along with it.
module tile_renderer #(
  parameter logic [13:0] NAME_BASE = 14'h0000,
  parameter logic [13:0] PAT_BASE  = 14'h0800,
  parameter logic [13:0] COL_BASE  = 14'h1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hSync,
  input  logic              vSync,
  input  logic signed [8:0] xPos,
  input  logic signed [8:0] yPos,
  input  logic              isActive,
  input  logic [3:0]        borderColor,
  output logic [13:0]       memAddr,
  output logic              memRead,
  input  logic [7:0]        memData,
  output logic [3:0]        pixel,
  output logic              hSyncOut,
  output logic              vSyncOut,
  output logic              activeOut
);

  logic [2:0]  phase;
  logic [7:0]  xNext;
  logic [4:0]  tx;
  logic        fetchEn;
  logic        rdReq;
  logic [13:0] addrReq;
  logic [13:0] addrHold;
  logic [7:0]  nameLat;
  logic [7:0]  patLat;
  logic [7:0]  colLat;
  logic [7:0]  shifter;
  logic [7:0]  activeColor;

  // Fetches run one tile ahead: xPos=-8..-1 prepares tile 0, 240..247 tile 31.
  assign phase   = xPos[2:0];
  assign xNext   = xPos[7:0] + 8'd8;
  assign tx      = xNext[7:3];
  assign fetchEn = (yPos >= 9'sd0) && (yPos <= 9'sd191) &&
                   (xPos >= -9'sd8) && (xPos <= 9'sd247);

  // Address/strobe per phase; outside read phases the held address is shown.
  always_comb begin
    rdReq   = 1'b0;
    addrReq = addrHold;
    if (fetchEn) begin
      case (phase)
        3'd0: begin
          rdReq   = 1'b1;
          addrReq = NAME_BASE + {4'd0, yPos[7:3], tx};
        end
        3'd2: begin
          rdReq   = 1'b1;
          addrReq = PAT_BASE + {3'd0, nameLat, yPos[2:0]};
        end
        3'd4: begin
          rdReq   = 1'b1;
          addrReq = COL_BASE + {6'd0, nameLat};
        end
        default: ;
      endcase
    end
  end

  // Reset must clear the bus outputs immediately, not just at the next edge.
  assign memRead = rdReq & ~reset;
  assign memAddr = reset ? 14'd0 : addrReq;

  // Remember the last issued address so memAddr holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      addrHold <= 14'd0;
    else if (rdReq) addrHold <= addrReq;
  end

  // Capture RAM data the cycle after each read (synchronous RAM latency).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nameLat <= 8'd0;
      patLat  <= 8'd0;
      colLat  <= 8'd0;
    end else if (fetchEn) begin
      case (phase)
        3'd1:    nameLat <= memData;
        3'd3:    patLat  <= memData;
        3'd5:    colLat  <= memData;
        default: ;
      endcase
    end
  end

  // Phase 7 hands the fetched tile to the shifter; otherwise shift out MSB first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shifter     <= 8'd0;
      activeColor <= 8'd0;
    end else if (phase == 3'd7) begin
      shifter     <= patLat;
      activeColor <= colLat;
    end else begin
      shifter     <= {shifter[6:0], 1'b0};
    end
  end

  // Output register: pixel and the syncs share one clock of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel     <= 4'd0;
      hSyncOut  <= 1'b0;
      vSyncOut  <= 1'b0;
      activeOut <= 1'b0;
    end else begin
      if (!isActive)      pixel <= borderColor;
      else if (shifter[7]) pixel <= activeColor[7:4];
      else                pixel <= activeColor[3:0];
      hSyncOut  <= hSync;
      vSyncOut  <= vSync;
      activeOut <= isActive;
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer with a synchronous video RAM model.
module tb_tile_renderer;

  logic              clk = 1'b0;
  logic              reset;
  logic              hSync, vSync;
  logic signed [8:0] xPos, yPos;
  logic              isActive;
  logic [3:0]        borderColor;
  logic [13:0]       memAddr;
  logic              memRead;
  logic [7:0]        memData = 8'h00;
  logic [3:0]        pixel;
  logic              hSyncOut, vSyncOut, activeOut;

  int tests = 0;
  int fails = 0;

  logic [7:0] vram [0:16383];

  tile_renderer dut (
    .clk(clk), .reset(reset), .hSync(hSync), .vSync(vSync),
    .xPos(xPos), .yPos(yPos), .isActive(isActive), .borderColor(borderColor),
    .memAddr(memAddr), .memRead(memRead), .memData(memData),
    .pixel(pixel), .hSyncOut(hSyncOut), .vSyncOut(vSyncOut), .activeOut(activeOut)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data valid the cycle after the strobe.
  always @(posedge clk) if (memRead) memData <= vram[memAddr];

  task automatic drive(input int x, input int y, input logic act);
    xPos = x[8:0];
    yPos = y[8:0];
    isActive = act;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; hSync = 1'b1; vSync = 1'b1; borderColor = 4'hF;
    drive(0, 0, 1'b1);
    tests++; if (pixel !== 4'd0) begin fails++; $display("FAIL reset_pixel: got %h exp 0", pixel); end
    tests++; if (memRead !== 1'b0) begin fails++; $display("FAIL reset_memRead: got %b exp 0", memRead); end
    tests++; if (memAddr !== 14'd0) begin fails++; $display("FAIL reset_memAddr: got %h exp 0", memAddr); end
    step(); step();
    tests++; if ({hSyncOut, vSyncOut, activeOut} !== 3'b000)
      begin fails++; $display("FAIL reset_syncs: got %b exp 000", {hSyncOut, vSyncOut, activeOut}); end
    tests++; if (pixel !== 4'd0) begin fails++; $display("FAIL reset_pixel_held: got %h exp 0", pixel); end
    reset = 1'b0; hSync = 1'b0; vSync = 1'b0; borderColor = 4'h0;
    drive(300, 300, 1'b0);
    step();
  endtask

  // Tile 0 of line 0: pattern A0, colors 3/C.
  task automatic test_basic();
    logic [3:0] exp [8] = '{4'h3, 4'hC, 4'h3, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC};
    for (int x = -8; x <= 7; x++) begin
      drive(x, 0, x >= 0);
      step();
      if (x >= 0) begin
        tests++;
        if (pixel !== exp[x]) begin fails++; $display("FAIL basic_pixel x=%0d: got %h exp %h", x, pixel, exp[x]); end
      end
    end
  endtask

  // Address trace for the tile-0 fetch on line 9, including held addresses.
  task automatic test_addr_trace();
    logic [13:0] expA [8] = '{14'h0020, 14'h0020, 14'h0829, 14'h0829,
                              14'h1005, 14'h1005, 14'h1005, 14'h1005};
    logic        expR [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int x = -8; x <= -1; x++) begin
      drive(x, 9, 1'b0);
      tests++;
      if (memRead !== expR[x+8]) begin fails++; $display("FAIL trace_memRead x=%0d: got %b exp %b", x, memRead, expR[x+8]); end
      tests++;
      if (memAddr !== expA[x+8]) begin fails++; $display("FAIL trace_memAddr x=%0d: got %h exp %h", x, memAddr, expA[x+8]); end
      step();
    end
  endtask

  // Line 192 with border only: border color everywhere, no reads at all.
  task automatic test_border();
    int reads = 0;
    borderColor = 4'h7;
    for (int x = -8; x <= 255; x++) begin
      drive(x, 192, 1'b0);
      if (memRead !== 1'b0) reads++;
      step();
      tests++;
      if (pixel !== 4'h7) begin fails++; $display("FAIL border_pixel x=%0d: got %h exp 7", x, pixel); end
    end
    tests++;
    if (reads !== 0) begin fails++; $display("FAIL border_noread: got %0d reads exp 0", reads); end
    borderColor = 4'h0;
  endtask

  // Last tile of line 16: name 07, pattern 81, colors 5/A.
  task automatic test_tile31();
    logic [3:0] exp [8] = '{4'h5, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h5};
    for (int x = 240; x <= 255; x++) begin
      drive(x, 16, 1'b1);
      if (x >= 248) begin
        tests++;
        if (memRead !== 1'b0) begin fails++; $display("FAIL tile31_noread x=%0d: got %b exp 0", x, memRead); end
      end
      step();
      if (x >= 248) begin
        tests++;
        if (pixel !== exp[x-248]) begin fails++; $display("FAIL tile31_pixel x=%0d: got %h exp %h", x, pixel, exp[x-248]); end
      end
    end
  endtask

  // Reset mid-line at xPos=100; tile 14 (name 09, pattern C3, colors 1/E) from 112.
  task automatic test_reset_mid();
    logic [3:0] exp [8] = '{4'h1, 4'h1, 4'hE, 4'hE, 4'hE, 4'hE, 4'h1, 4'h1};
    hSync = 1'b1; vSync = 1'b1;
    for (int x = 88; x <= 99; x++) begin
      drive(x, 24, 1'b1);
      step();
    end
    tests++;
    if (pixel !== 4'hB) begin fails++; $display("FAIL rmid_pre_pixel: got %h exp b", pixel); end
    drive(100, 24, 1'b1);
    tests++;
    if (memRead !== 1'b1) begin fails++; $display("FAIL rmid_pre_memRead: got %b exp 1", memRead); end
    #1 reset = 1'b1;
    #1;
    tests++; if (pixel !== 4'd0) begin fails++; $display("FAIL rmid_pixel: got %h exp 0", pixel); end
    tests++; if ({hSyncOut, vSyncOut, activeOut} !== 3'b000)
      begin fails++; $display("FAIL rmid_syncs: got %b exp 000", {hSyncOut, vSyncOut, activeOut}); end
    tests++; if (memRead !== 1'b0) begin fails++; $display("FAIL rmid_memRead: got %b exp 0", memRead); end
    tests++; if (memAddr !== 14'd0) begin fails++; $display("FAIL rmid_memAddr: got %h exp 0", memAddr); end
    step();
    reset = 1'b0;
    for (int x = 101; x <= 119; x++) begin
      drive(x, 24, 1'b1);
      step();
      if (x <= 103) begin
        tests++;
        if (pixel !== 4'd0) begin fails++; $display("FAIL rmid_zero x=%0d: got %h exp 0", x, pixel); end
      end
      if (x >= 112) begin
        tests++;
        if (pixel !== exp[x-112]) begin fails++; $display("FAIL rmid_pixel x=%0d: got %h exp %h", x, pixel, exp[x-112]); end
      end
    end
    hSync = 1'b0; vSync = 1'b0;
  endtask

  // Syncs must still show the old value before the edge and the new one after.
  task automatic test_sync();
    logic [7:0] hp = 8'b1011_0010;
    logic [7:0] vp = 8'b0110_1001;
    logic       ph = 1'b0;
    logic       pv = 1'b0;
    drive(300, 300, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      hSync = hp[i]; vSync = vp[i];
      #1;
      tests++;
      if ({hSyncOut, vSyncOut} !== {ph, pv})
        begin fails++; $display("FAIL sync_hold i=%0d: got %b exp %b", i, {hSyncOut, vSyncOut}, {ph, pv}); end
      step();
      tests++;
      if ({hSyncOut, vSyncOut} !== {hp[i], vp[i]})
        begin fails++; $display("FAIL sync_follow i=%0d: got %b exp %b", i, {hSyncOut, vSyncOut}, {hp[i], vp[i]}); end
      ph = hp[i]; pv = vp[i];
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
    vram[14'h0000] = 8'h05; vram[14'h0828] = 8'hA0; vram[14'h1005] = 8'h3C;
    vram[14'h0020] = 8'h05;
    vram[14'h005F] = 8'h07; vram[14'h0838] = 8'h81; vram[14'h1007] = 8'h5A;
    vram[14'h006E] = 8'h09; vram[14'h0848] = 8'hC3; vram[14'h1009] = 8'h1E;
    vram[14'h1000] = 8'hBB;
    reset = 1'b1; hSync = 1'b0; vSync = 1'b0; borderColor = 4'h0;
    xPos = '0; yPos = '0; isActive = 1'b0;
    test_reset();
    test_basic();
    test_addr_trace();
    test_border();
    test_tile31();
    test_reset_mid();
    test_sync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tile_renderer.md
TILE_RENDERER -- requirements
Module: tile_renderer

Interface
REQ-001 SHALL have parameter NAME_BASE, default 14'h0000, meaning base address of the 32x24-byte name table.
REQ-002 SHALL have parameter PAT_BASE, default 14'h0800, meaning base address of the 256x8-byte pattern table.
REQ-003 SHALL have parameter COL_BASE, default 14'h1000, meaning base address of the 256-byte color table.
REQ-004 clk  input  1  single clock for all sequential logic.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 hSync, vSync  input  1 each  sync from the timing generator.
REQ-007 xPos, yPos  input  9 each, signed  pixel position from the timing generator; negative means border or blanking.
REQ-008 isActive  input  1  high when the position is inside the 256x192 active region.
REQ-009 borderColor  input  4  palette index shown outside the active region.
REQ-010 memAddr  output  14  video RAM read address.
REQ-011 memRead  output  1  read strobe; memAddr is meaningful only while high.
REQ-012 memData  input  8  RAM read data, valid the cycle after memAddr/memRead (synchronous RAM).
REQ-013 pixel  output  4  registered palette index.
REQ-014 hSyncOut, vSyncOut, activeOut  output  1 each  hSync, vSync and isActive delayed to align with pixel.

Function
REQ-015 The fetch phase SHALL be xPos[2:0]; fetches for tile column tx = (xPos+8)[7:3] SHALL occur only when yPos is in 0..191 and xPos is in -8..247. Otherwise memRead=0 and the latches hold.
REQ-016 Phase 0 SHALL drive memAddr = NAME_BASE + {yPos[7:3], tx} (10-bit offset) with memRead=1.
REQ-017 Phase 1 SHALL capture memData into the name latch (8 bits) with memRead=0.
REQ-018 Phase 2 SHALL drive memAddr = PAT_BASE + {name, yPos[2:0]} (11-bit offset) with memRead=1.
REQ-019 Phase 3 SHALL capture memData into the pattern latch with memRead=0.
REQ-020 Phase 4 SHALL drive memAddr = COL_BASE + name with memRead=1.
REQ-021 Phase 5 SHALL capture memData into the color latch with memRead=0.
REQ-022 Phase 6 SHALL perform no memory access (memRead=0).
REQ-023 On the clock edge ending phase 7, the shifter SHALL load the pattern latch and the active color register SHALL load the color latch.
REQ-024 On every other clock edge the shifter SHALL shift left by one and fill 0.
REQ-025 The pixel bit for a given xPos SHALL be shifter[7], sampled in the cycle that xPos is presented.
REQ-026 pixel SHALL register, each cycle, one of:
- borderColor if isActive=0;
- otherwise activeColor[7:4] if the bit is 1;
- otherwise activeColor[3:0].
REQ-027 pixel, hSyncOut, vSyncOut and activeOut SHALL have a latency of exactly 1 clock relative to their inputs.
REQ-028 The memAddr addition SHALL be 14-bit, wrapping modulo 2^14.
REQ-029 When memRead=0, memAddr SHALL hold its last value.
REQ-030 The fetch at xPos=-8..-1 SHALL prepare tile 0, so pixel column 0 is correct with no extra delay.
REQ-031 Tile 31 SHALL be fetched at xPos=240..247; no fetch SHALL occur for xPos>=248.
REQ-032 hShift changes that move xPos SHALL need no special handling, because the phase follows xPos[2:0] directly.

Reset
REQ-033 While reset=1, the following SHALL be 0 immediately, independent of clk: pixel, hSyncOut, vSyncOut, activeOut, memRead, memAddr, and all latches, shifter and active color.
REQ-034 After reset deasserts mid-line, output SHALL show palette index 0 in active cells until the next phase-7 load, then be correct.

Verification
REQ-035 Name[0]=8'h05, pattern[5*8+0]=8'hA0, color[5]=8'h3C; drive line yPos=0 -> pixel at xPos 0..7 (one clock later) = 3,C,3,C,C,C,C,C.
REQ-036 Trace memAddr/memRead for xPos=-8..-1, yPos=9 (with name data 8'h05) -> 0x0020 at phase 0, 0x0829 at phase 2, 0x1005 at phase 4, memRead high only in those phases.
REQ-037 isActive=0 with borderColor=4'h7 -> pixel=7; and with yPos=192 -> no memRead across the whole line.
REQ-038 Sweep xPos 240..255 -> tile 31 pixels correct at 248..255; no memRead at 248..255.
REQ-039 Assert reset at xPos=100, asynchronously between edges -> all outputs 0 before the next edge; release -> pixels correct from xPos 112.
REQ-040 Toggle hSync/vSync -> hSyncOut/vSyncOut follow exactly 1 clock later.
